// File: rtl/bht_port_scheduler.sv
// bht_port_scheduler
// Arbitrates a single-port branch history table (2-bit saturating counters)
// between fetch-stage lookups and execute-stage updates. Resolved updates are
// queued in a small FIFO and applied as read-modify-write pairs whenever no
// lookup claims the port, or unconditionally once the FIFO is full.
//
// Ports
//   clk, arst_n                       clock, asynchronous active-low reset
//   lookup_valid/idx/ready            prediction request handshake
//   pred_valid, pred_taken            prediction, one cycle after acceptance
//   upd_valid/idx/taken/ready         resolved-branch update handshake
//   busy                              initialisation sweep in progress
//   tbl_en/we/addr/wdata, tbl_rdata   single-port table, 1-cycle read latency
//   stat_lookups, stat_updates        only when BHT_SCHED_STATS_EN is defined
//
// Build option: define BHT_SCHED_STATS_EN to add the saturating 16-bit
// lookup/update activity counters.
module bht_port_scheduler #(
  parameter int unsigned LOWER  = 5,
  parameter int unsigned QDEPTH = 4
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             lookup_valid,
  input  logic [LOWER-1:0] lookup_idx,
  output logic             lookup_ready,
  output logic             pred_valid,
  output logic             pred_taken,
  input  logic             upd_valid,
  input  logic [LOWER-1:0] upd_idx,
  input  logic             upd_taken,
  output logic             upd_ready,
  output logic             busy,
  output logic             tbl_en,
  output logic             tbl_we,
  output logic [LOWER-1:0] tbl_addr,
  output logic [1:0]       tbl_wdata,
  input  logic [1:0]       tbl_rdata
`ifdef BHT_SCHED_STATS_EN
  ,
  output logic [15:0]      stat_lookups,
  output logic [15:0]      stat_updates
`endif
);

  localparam int unsigned PtrW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CntW = $clog2(QDEPTH + 1);

  typedef enum logic [1:0] {StInit, StRun, StUpdWr} state_e;

  state_e           state_q, state_d;
  logic [LOWER-1:0] sweep_q, sweep_d;
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             pred_valid_q;

  logic [LOWER-1:0] q_idx   [QDEPTH];
  logic             q_taken [QDEPTH];

  logic             full, empty, push, pop, lookup_acc;
  logic             en, we;
  logic [LOWER-1:0] head_idx;
  logic             head_taken;

  assign full       = (count_q == CntW'(QDEPTH));
  assign empty      = (count_q == '0);
  assign push       = upd_valid && !full;
  assign upd_ready  = !full;
  assign head_idx   = q_idx[rd_ptr_q];
  assign head_taken = q_taken[rd_ptr_q];
  assign busy       = (state_q == StInit);

  always_comb begin
    state_d      = state_q;
    sweep_d      = sweep_q;
    en           = 1'b0;
    we           = 1'b0;
    tbl_addr     = '0;
    tbl_wdata    = 2'b00;
    lookup_ready = 1'b0;
    lookup_acc   = 1'b0;
    pop          = 1'b0;
    unique case (state_q)
      StInit: begin
        en        = 1'b1;
        we        = 1'b1;
        tbl_addr  = sweep_q;
        tbl_wdata = 2'b01;
        sweep_d   = sweep_q + LOWER'(1);
        if (sweep_q == {LOWER{1'b1}}) state_d = StRun;
      end
      StRun: begin
        // A full FIFO drops lookup_ready, which hands the port to the drain.
        lookup_ready = !full;
        if (lookup_valid && !full) begin
          en         = 1'b1;
          tbl_addr   = lookup_idx;
          lookup_acc = 1'b1;
        end else if (!empty) begin
          en       = 1'b1;
          tbl_addr = head_idx;
          state_d  = StUpdWr;
        end
      end
      StUpdWr: begin
        en       = 1'b1;
        we       = 1'b1;
        tbl_addr = head_idx;
        pop      = 1'b1;
        state_d  = StRun;
        if (head_taken) tbl_wdata = (tbl_rdata == 2'b11) ? 2'b11 : tbl_rdata + 2'b01;
        else            tbl_wdata = (tbl_rdata == 2'b00) ? 2'b00 : tbl_rdata - 2'b01;
      end
      default: state_d = StInit;
    endcase
  end

  // The INIT sweep is combinational from state, so the port is forced quiet
  // while reset is held.
  assign tbl_en = en & arst_n;
  assign tbl_we = we & arst_n;

  assign pred_valid = pred_valid_q;
  assign pred_taken = pred_valid_q & tbl_rdata[1];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= StInit;
      sweep_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pred_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      pred_valid_q <= lookup_acc;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + CntW'(1);
      else if (pop && !push) count_q <= count_q - CntW'(1);
    end
  end

  // Payload storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      q_idx[wr_ptr_q]   <= upd_idx;
      q_taken[wr_ptr_q] <= upd_taken;
    end
  end

`ifdef BHT_SCHED_STATS_EN
  logic [15:0] stat_lookups_q, stat_updates_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stat_lookups_q <= '0;
      stat_updates_q <= '0;
    end else begin
      if (lookup_acc && stat_lookups_q != 16'hFFFF) stat_lookups_q <= stat_lookups_q + 16'd1;
      if (pop && stat_updates_q != 16'hFFFF)        stat_updates_q <= stat_updates_q + 16'd1;
    end
  end

  assign stat_lookups = stat_lookups_q;
  assign stat_updates = stat_updates_q;
`endif

endmodule

// File: tb/tb_bht_port_scheduler.sv
// Directed bench for bht_port_scheduler (LOWER=5, QDEPTH=4). A behavioural
// single-port table with 1-cycle read latency is attached and every table
// write is logged so write order and values can be compared with hand-worked
// expectations.
module tb_bht_port_scheduler;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       lookup_valid, upd_valid, upd_taken;
  logic [4:0] lookup_idx, upd_idx;
  logic       lookup_ready, pred_valid, pred_taken, upd_ready, busy;
  logic       tbl_en, tbl_we;
  logic [4:0] tbl_addr;
  logic [1:0] tbl_wdata, tbl_rdata;
`ifdef BHT_SCHED_STATS_EN
  logic [15:0] stat_lookups, stat_updates;
`endif

  int checks   = 0;
  int failures = 0;
  int cnt;

  logic [1:0] mem [32];
  logic [4:0] log_addr [$];
  logic [1:0] log_data [$];

  always #5 clk = ~clk;

  bht_port_scheduler #(.LOWER(5), .QDEPTH(4)) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .lookup_valid (lookup_valid),
    .lookup_idx   (lookup_idx),
    .lookup_ready (lookup_ready),
    .pred_valid   (pred_valid),
    .pred_taken   (pred_taken),
    .upd_valid    (upd_valid),
    .upd_idx      (upd_idx),
    .upd_taken    (upd_taken),
    .upd_ready    (upd_ready),
    .busy         (busy),
    .tbl_en       (tbl_en),
    .tbl_we       (tbl_we),
    .tbl_addr     (tbl_addr),
    .tbl_wdata    (tbl_wdata),
    .tbl_rdata    (tbl_rdata)
`ifdef BHT_SCHED_STATS_EN
    ,
    .stat_lookups (stat_lookups),
    .stat_updates (stat_updates)
`endif
  );

  // Single-port table model.
  always @(posedge clk) begin
    if (tbl_en) begin
      if (tbl_we) begin
        mem[tbl_addr] <= tbl_wdata;
        log_addr.push_back(tbl_addr);
        log_data.push_back(tbl_wdata);
      end else begin
        tbl_rdata <= mem[tbl_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic upd(input logic [4:0] idx, input logic tk);
    upd_valid = 1'b1;
    upd_idx   = idx;
    upd_taken = tk;
    step();
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic chk_log(input string tag, input int i, input logic [4:0] a, input logic [1:0] d);
    if (i < log_addr.size()) begin
      chk({tag, "_addr"}, 32'(log_addr[i]), 32'(a));
      chk({tag, "_data"}, 32'(log_data[i]), 32'(d));
    end else begin
      chk({tag, "_missing"}, 32'(log_addr.size()), 32'(i + 1));
    end
  endtask

  initial begin
    arst_n       = 1'b0;
    lookup_valid = 1'b0;
    lookup_idx   = '0;
    upd_valid    = 1'b0;
    upd_idx      = '0;
    upd_taken    = 1'b0;
    #2;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_tbl_en", 32'(tbl_en), 32'd0);
    chk("rst_tbl_we", 32'(tbl_we), 32'd0);
    chk("rst_pred_valid", 32'(pred_valid), 32'd0);
    chk("rst_pred_taken", 32'(pred_taken), 32'd0);
    chk("rst_upd_ready", 32'(upd_ready), 32'd1);
    step();
    arst_n = 1'b1;

    // Initialisation sweep.
    chk("init_lookup_ready", 32'(lookup_ready), 32'd0);
    wait_init(cnt);
    chk("init_busy_cycles", 32'(cnt), 32'd32);
    chk("init_write_count", 32'(log_addr.size()), 32'd32);
    for (int i = 0; i < 32; i++) chk_log("init_sweep", i, 5'(i), 2'b01);
    chk("init_done_lookup_ready", 32'(lookup_ready), 32'd1);
    chk("idle_tbl_en", 32'(tbl_en), 32'd0);
    clear_log();

    // Lookup of a freshly initialised entry.
    lookup_valid = 1'b1;
    lookup_idx   = 5'd3;
    #1;
    chk("lk3_tbl_addr", 32'(tbl_addr), 32'd3);
    chk("lk3_tbl_we", 32'(tbl_we), 32'd0);
    step();
    lookup_valid = 1'b0;
    chk("lk3_pred_valid", 32'(pred_valid), 32'd1);
    chk("lk3_pred_taken", 32'(pred_taken), 32'd0);
    step();
    chk("lk3_pred_valid_drop", 32'(pred_valid), 32'd0);

    // Three taken updates on idx 3: 01 -> 10 -> 11 -> 11.
    upd(5'd3, 1'b1);
    upd(5'd3, 1'b1);
    upd(5'd3, 1'b1);
    upd_valid = 1'b0;
    repeat (8) step();
    chk("sat_up_count", 32'(log_addr.size()), 32'd3);
    chk_log("sat_up0", 0, 5'd3, 2'b10);
    chk_log("sat_up1", 1, 5'd3, 2'b11);
    chk_log("sat_up2", 2, 5'd3, 2'b11);
    clear_log();
    lookup_valid = 1'b1;
    lookup_idx   = 5'd3;
    step();
    lookup_valid = 1'b0;
    chk("lk3b_pred_valid", 32'(pred_valid), 32'd1);
    chk("lk3b_pred_taken", 32'(pred_taken), 32'd1);

    // Saturation at both ends.
    upd(5'd5, 1'b0);
    upd(5'd5, 1'b0);
    upd(5'd3, 1'b1);
    upd_valid = 1'b0;
    repeat (8) step();
    chk("sat_lim_count", 32'(log_addr.size()), 32'd3);
    chk_log("sat_dn0", 0, 5'd5, 2'b00);
    chk_log("sat_dn1", 1, 5'd5, 2'b00);
    chk_log("sat_hi", 2, 5'd3, 2'b11);
    clear_log();

    // Lookup behind a queued update reads the stale value.
    upd(5'd7, 1'b1);
    upd_valid    = 1'b0;
    lookup_valid = 1'b1;
    lookup_idx   = 5'd7;
    #1;
    chk("stale_lookup_ready", 32'(lookup_ready), 32'd1);
    chk("stale_tbl_addr", 32'(tbl_addr), 32'd7);
    step();
    lookup_valid = 1'b0;
    chk("stale_pred_valid", 32'(pred_valid), 32'd1);
    chk("stale_pred_taken", 32'(pred_taken), 32'd0);
    repeat (4) step();
    chk_log("stale_applied", 0, 5'd7, 2'b10);
    clear_log();

    // Updates queued during INIT fill the FIFO; drain wins once out of INIT.
    arst_n = 1'b0;
    #2;
    arst_n = 1'b1;
    lookup_valid = 1'b1;
    lookup_idx   = 5'd9;
    upd(5'd10, 1'b1);
    upd(5'd11, 1'b0);
    upd(5'd12, 1'b1);
    upd(5'd13, 1'b1);
    upd_idx   = 5'd14;
    upd_taken = 1'b0;
    #1;
    chk("full_upd_ready", 32'(upd_ready), 32'd0);
    chk("full_init_lookup_ready", 32'(lookup_ready), 32'd0);
    upd_valid = 1'b0;
    wait_init(cnt);
    chk("full_init_done", 32'(busy), 32'd0);
    clear_log();
    chk("drain_lookup_ready", 32'(lookup_ready), 32'd0);
    chk("drain_rd_addr", 32'(tbl_addr), 32'd10);
    chk("drain_rd_we", 32'(tbl_we), 32'd0);
    step();
    chk("drain_wr_lookup_ready", 32'(lookup_ready), 32'd0);
    chk("drain_wr_we", 32'(tbl_we), 32'd1);
    chk("drain_wr_data", 32'(tbl_wdata), 32'd2);
    step();
    chk("drain_after_lookup_ready", 32'(lookup_ready), 32'd1);
    chk("drain_after_addr", 32'(tbl_addr), 32'd9);
    step();
    lookup_valid = 1'b0;
    chk("drain_pred_valid", 32'(pred_valid), 32'd1);
    chk("drain_pred_taken", 32'(pred_taken), 32'd0);
    repeat (10) step();
    chk("drain_write_count", 32'(log_addr.size()), 32'd4);
    chk_log("drain0", 0, 5'd10, 2'b10);
    chk_log("drain1", 1, 5'd11, 2'b00);
    chk_log("drain2", 2, 5'd12, 2'b10);
    chk_log("drain3", 3, 5'd13, 2'b10);
    clear_log();

    // Reset while in UPD_WR with two updates queued.
    upd(5'd20, 1'b1);
    upd(5'd21, 1'b1);
    upd_valid = 1'b0;
    chk("mid_upd_we", 32'(tbl_we), 32'd1);
    chk("mid_upd_addr", 32'(tbl_addr), 32'd20);
    arst_n = 1'b0;
    #1;
    chk("mid_rst_tbl_we", 32'(tbl_we), 32'd0);
    chk("mid_rst_tbl_en", 32'(tbl_en), 32'd0);
    #1;
    arst_n = 1'b1;
    #1;
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_sweep_addr", 32'(tbl_addr), 32'd0);
`ifdef BHT_SCHED_STATS_EN
    chk("mid_stat_lookups", 32'(stat_lookups), 32'd0);
    chk("mid_stat_updates", 32'(stat_updates), 32'd0);
`endif
    wait_init(cnt);
    chk("mid_busy_cycles", 32'(cnt), 32'd32);
    chk("mid_write_count", 32'(log_addr.size()), 32'd32);
    chk_log("mid_first", 0, 5'd0, 2'b01);
    chk_log("mid_last", 31, 5'd31, 2'b01);
    chk("mid_fifo_empty", 32'(tbl_en), 32'd0);
    chk("mid_lookup_ready", 32'(lookup_ready), 32'd1);
    repeat (4) step();
    chk("mid_no_late_write", 32'(log_addr.size()), 32'd32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
